sdram_rd_fifo: RTL
==================

Name: sdram_rd_fifo

Overview:
- Read-side counterpart of the USB-to-SDRAM write path, running in the sdram_clk domain.
- On a start command it issues burst read requests to the SDRAM controller over a valid/ready request channel.
- It pushes the returned words in order into the write port of the SDRAM-to-USB async FIFO; the FX2 upload logic drains that FIFO on the cyp_clk side.
- It only requests a burst when the FIFO has room for all of it, so the FIFO never overflows.

Parameters:
- ADDR_W, 24, SDRAM word-address width.
- DATA_W, 16, data width.
- BURST_LEN, 8, words returned per read request (power of 2).
- FIFO_AW, 9, async FIFO address width; depth is 2**FIFO_AW.

Ports:
- sdram_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- sdram_init_done  in  1  SDRAM ready; start is ignored while this is low.
- start  in  1  one-cycle command pulse, accepted only when idle.
- start_addr  in  ADDR_W  first word address.
- len_words  in  ADDR_W  number of words to transfer.
- abort  in  1  stop the transfer after the current burst.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on normal completion.
- err_ovf  out  1  sticky flag: a write was attempted while fifo_wfull was high.
- rd_addr  out  ADDR_W  burst start address.
- rd_valid  out  1  read request valid.
- rd_ready  in  1  controller accepts the request.
- rd_data  in  DATA_W  returned read data.
- rd_data_valid  in  1  rd_data qualifier.
- fifo_wen  out  1  FIFO write enable.
- fifo_wdata  out  DATA_W  FIFO write data.
- fifo_wfull  in  1  FIFO full.
- fifo_wcount  in  FIFO_AW+1  FIFO write-side fill level.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset asserted mid-transfer behaves the same: everything is 0 on the next edge, and any outstanding return data is ignored until a new start.
- Capture: start is accepted only in IDLE with sdram_init_done=1. On acceptance, latch addr=start_addr and remaining=len_words.
- Zero length: start with len_words=0 gives a done pulse one cycle later, no requests, and busy stays low.
- IDLE -> SPACE on start with nonzero length; busy=1 in every state except IDLE.
- SPACE: wait until (2**FIFO_AW - fifo_wcount) >= BURST_LEN+1. The +1 covers the registered write still in flight. Then go to REQ.
- REQ: drive rd_valid=1 with rd_addr=addr. rd_addr is held stable until rd_ready. On rd_valid&&rd_ready, go to RECV and clear the beat counter.
- Only one burst is outstanding at a time.
- RECV: on each rd_data_valid, increment the beat counter.
  - If remaining>0, push the word and decrement remaining.
  - If remaining=0, drop the word; this is how a non-multiple-of-BURST_LEN length truncates the last burst.
- FIFO write is registered: fifo_wen and fifo_wdata follow rd_data_valid and rd_data by exactly one cycle.
- End of burst (beat BURST_LEN-1 received):
  - addr increments by BURST_LEN, modulo 2**ADDR_W, so 0xFFFFF8 + 8 wraps to 0x000000.
  - If remaining=0 (after this beat) or an abort is pending, go to IDLE; otherwise go to SPACE.
- done pulses one cycle after the last fifo_wen (same cycle it would otherwise follow), and only on completion without abort.
- Abort:
  - A pulse in any busy state sets abort_pend.
  - In SPACE, or in REQ before acceptance, go to IDLE next cycle, drop rd_valid, no done.
  - In RECV, the current burst drains fully into the FIFO, then go to IDLE, no done.
  - Abort in IDLE is ignored.
- Overflow guard: if a push coincides with fifo_wfull=1, suppress fifo_wen and set err_ovf. err_ovf clears only on rst or on the next accepted start.
- rd_data_valid seen outside RECV is ignored.
- start while busy is ignored.
- start and abort in the same idle cycle: start wins and abort is ignored.

Decomposition:
- Shared package sdram_rd_pkg holds:
  - the ADDR_W, DATA_W and BURST_LEN defaults;
  - the state encoding {IDLE, SPACE, REQ, RECV};
  - a free-space function.
- Sub-module sdram_rd_addr_gen holds the address/remaining counters, the wrap logic and the truncation decision. The top module keeps the FSM, handshake and FIFO write register.

Test Plan:
- Basic 16-word transfer:
  - Stimulus: start_addr=0x000100, len_words=16, FIFO empty, rd_ready=1, data returned 3 cycles after each accept.
  - Response: requests at 0x000100 then 0x000108; 16 in-order fifo_wen; done one cycle after the last write; busy then 0.
- Truncation:
  - Stimulus: len_words=10.
  - Response: two requests; 10 writes; beats 11-16 dropped; done asserted.
- Backpressure (FIFO_AW=9):
  - Stimulus: fifo_wcount=504.
  - Response: rd_valid stays 0 until fifo_wcount<=503, then one request.
  - Also hold rd_ready=0 for 5 cycles: rd_addr must stay stable throughout.
- Wrap:
  - Stimulus: start_addr=0xFFFFF8, len_words=16.
  - Response: rd_addr 0xFFFFF8, then 0x000000.
- Abort:
  - Stimulus: abort during RECV of burst 1 of 4.
  - Response: 8 writes complete, no further rd_valid, busy falls, no done.
- Gating, reset and overflow:
  - start with sdram_init_done=0 is ignored.
  - rst mid-RECV sets all outputs 0 on the next edge.
  - Forcing fifo_wfull=1 during a push suppresses the write and sets err_ovf, which stays 1 until the next start.

Source files
------------

// File: rtl/sdram_rd_pkg.sv
// Shared types and defaults for the SDRAM read path.
// State encoding and FIFO free-space helper.
package sdram_rd_pkg;

    localparam int ADDR_W_DEF    = 24;
    localparam int DATA_W_DEF    = 16;
    localparam int BURST_LEN_DEF = 8;
    localparam int FIFO_AW_DEF   = 9;

    typedef enum logic [1:0] {
        IDLE,
        SPACE,
        REQ,
        RECV
    } rd_state_e;

    // Free slots left in a FIFO of the given depth; never underflows.
    function automatic int unsigned free_space(
        input int unsigned depth,
        input int unsigned wcount
    );
        return (wcount >= depth) ? 0 : depth - wcount;
    endfunction

endpackage

// File: rtl/sdram_rd_addr_gen.sv
// Burst address and remaining-word counters for the SDRAM read path.
// Decides whether each returned beat is kept or dropped.
module sdram_rd_addr_gen
    import sdram_rd_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] len_words,
    input  logic              beat_in,
    input  logic              burst_end,
    output logic [ADDR_W-1:0] addr,
    output logic              keep,
    output logic              rem_last
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;

    // A beat is stored only while words remain; otherwise it is truncated.
    assign keep     = (rem_q != '0);
    assign rem_last = (rem_q <= ADDR_W'(1));
    assign addr     = addr_q;

    // Next address/remaining: load on start, count down per kept beat.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load) begin
            addr_d = start_addr;
            rem_d  = len_words;
        end else begin
            if (beat_in && keep) begin
                rem_d = rem_q - ADDR_W'(1);
            end
            if (burst_end) begin
                addr_d = addr_q + ADDR_W'(BURST_LEN);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

endmodule

// File: rtl/sdram_rd_fifo.sv
// SDRAM burst reader feeding the SDRAM-to-USB async FIFO.
// Requests a burst only when the FIFO can hold all of it.
module sdram_rd_fifo
    import sdram_rd_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int FIFO_AW   = FIFO_AW_DEF
) (
    input  logic              sdram_clk,
    input  logic              rst,
    input  logic              sdram_init_done,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] len_words,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              rd_ready,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_data_valid,
    output logic              fifo_wen,
    output logic [DATA_W-1:0] fifo_wdata,
    input  logic              fifo_wfull,
    input  logic [FIFO_AW:0]  fifo_wcount
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    // One extra slot covers the registered write still in flight.
    localparam int unsigned NEED  = BURST_LEN + 1;

    rd_state_e         state_q, state_d;
    logic              abort_pend_q, abort_pend_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_pre_q, done_pre_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic load, beat_in, burst_end, keep, rem_last, has_room;

    assign has_room = free_space(DEPTH, 32'(fifo_wcount)) >= NEED;

    sdram_rd_addr_gen #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN)
    ) u_addr_gen (
        .clk        (sdram_clk),
        .rst        (rst),
        .load       (load),
        .start_addr (start_addr),
        .len_words  (len_words),
        .beat_in    (beat_in),
        .burst_end  (burst_end),
        .addr       (rd_addr),
        .keep       (keep),
        .rem_last   (rem_last)
    );

    assign busy       = (state_q != IDLE);
    assign rd_valid   = (state_q == REQ);
    assign fifo_wen   = wen_q;
    assign fifo_wdata = wdata_q;
    assign done       = done_q;
    assign err_ovf    = err_q;

    // Next-state, handshake and FIFO write decisions.
    always_comb begin
        state_d      = state_q;
        abort_pend_d = abort_pend_q;
        beat_d       = beat_q;
        wen_d        = 1'b0;
        wdata_d      = wdata_q;
        done_pre_d   = 1'b0;
        done_d       = done_pre_q;
        err_d        = err_q;
        load         = 1'b0;
        beat_in      = 1'b0;
        burst_end    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && sdram_init_done) begin
                    load         = 1'b1;
                    err_d        = 1'b0;
                    abort_pend_d = 1'b0;
                    if (len_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SPACE;
                    end
                end
            end
            SPACE: begin
                if (abort || abort_pend_q) begin
                    state_d      = IDLE;
                    abort_pend_d = 1'b0;
                end else if (has_room) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (rd_ready) begin
                    state_d = RECV;
                    beat_d  = '0;
                    if (abort) begin
                        abort_pend_d = 1'b1;
                    end
                end else if (abort) begin
                    state_d      = IDLE;
                    abort_pend_d = 1'b0;
                end
            end
            RECV: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (rd_data_valid) begin
                    beat_in = 1'b1;
                    beat_d  = beat_q + BW'(1);
                    if (keep) begin
                        if (fifo_wfull) begin
                            err_d = 1'b1;
                        end else begin
                            wen_d   = 1'b1;
                            wdata_d = rd_data;
                        end
                    end
                    if (beat_q == LAST_BEAT) begin
                        burst_end = 1'b1;
                        if (rem_last || abort || abort_pend_q) begin
                            state_d      = IDLE;
                            abort_pend_d = 1'b0;
                            done_pre_d   = rem_last && !abort
                                           && !abort_pend_q;
                        end else begin
                            state_d = SPACE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, write register and status flags.
    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            abort_pend_q <= 1'b0;
            beat_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            done_pre_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            abort_pend_q <= abort_pend_d;
            beat_q       <= beat_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            done_pre_q   <= done_pre_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

endmodule
